// File: rtl/io_port_responder.sv
// I/O port responder: a data port backed by TX/RX byte FIFOs plus a status/control port.
// CPU bus accesses are edge-detected so long strobes act exactly once.
module io_port_responder #(
  parameter logic [7:0]  PORT_BASE  = 8'h00,
  parameter int unsigned DEPTH_LOG2 = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] addr_bus,
  input  logic       mem_io,
  input  logic       c_ri,
  input  logic       c_ro,
  inout  wire  [7:0] bus,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic       rx_ready
);

  localparam int unsigned DEPTH = 2 ** DEPTH_LOG2;
  localparam logic [7:0] STATUS_ADDR = PORT_BASE + 8'd1;
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE = DEPTH_LOG2'(1);
  localparam logic [DEPTH_LOG2:0]   CNT_ONE = (DEPTH_LOG2 + 1)'(1);

  // FIFO storage and state
  logic [7:0]            tx_mem [DEPTH];
  logic [7:0]            rx_mem [DEPTH];
  logic [DEPTH_LOG2-1:0] tx_wr_ptr_q, tx_wr_ptr_d, tx_rd_ptr_q, tx_rd_ptr_d;
  logic [DEPTH_LOG2-1:0] rx_wr_ptr_q, rx_wr_ptr_d, rx_rd_ptr_q, rx_rd_ptr_d;
  logic [DEPTH_LOG2:0]   tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;
  logic                  tx_of_q, tx_of_d, rx_uf_q, rx_uf_d;

  // Registered access strobes for edge detection
  logic wr_d_q, wr_s_q, rd_d_q, rd_s_q;

  logic hit_d, hit_s, wr_d, wr_s, rd_d, rd_s;
  logic wr_d_fire, wr_s_fire, rd_d_end, rd_s_end;
  logic tx_full, tx_empty, rx_full, rx_empty;
  logic tx_push, tx_pop, tx_flush, rx_push, rx_pop, rx_flush;
  logic [7:0] rx_head, status;

  // Address decode and access edge detection
  always_comb begin
    hit_d     = mem_io && (addr_bus == PORT_BASE);
    hit_s     = mem_io && (addr_bus == STATUS_ADDR);
    wr_d      = c_ri && hit_d;
    wr_s      = c_ri && hit_s;
    rd_d      = c_ro && hit_d;
    rd_s      = c_ro && hit_s;
    wr_d_fire = wr_d && !wr_d_q;
    wr_s_fire = wr_s && !wr_s_q;
    // Read side effects land at the end of the access so the bus stays stable meanwhile
    rd_d_end  = !rd_d && rd_d_q;
    rd_s_end  = !rd_s && rd_s_q;
  end

  // FIFO flags, handshakes and status byte; count MSB is set only at DEPTH
  always_comb begin
    tx_full  = tx_cnt_q[DEPTH_LOG2];
    tx_empty = (tx_cnt_q == '0);
    rx_full  = rx_cnt_q[DEPTH_LOG2];
    rx_empty = (rx_cnt_q == '0);
    tx_valid = !tx_empty;
    tx_data  = tx_mem[tx_rd_ptr_q];
    rx_ready = !rx_full;
    rx_head  = rx_empty ? 8'h00 : rx_mem[rx_rd_ptr_q];
    // Full TX rejects a CPU write even if the sink drains on the same edge
    tx_push  = wr_d_fire && !tx_full;
    tx_pop   = tx_valid && tx_ready;
    tx_flush = wr_s_fire && bus[0];
    rx_push  = rx_valid && rx_ready;
    rx_pop   = rd_d_end && !rx_empty;
    rx_flush = wr_s_fire && bus[1];
    status   = {2'b00, rx_uf_q, tx_of_q, rx_empty, rx_full, tx_empty, tx_full};
  end

  assign bus = rd_d ? rx_head : (rd_s ? status : 8'hzz);

  // TX FIFO next state; flush wins over any same-edge push/pop
  always_comb begin
    tx_wr_ptr_d = tx_wr_ptr_q;
    tx_rd_ptr_d = tx_rd_ptr_q;
    tx_cnt_d    = tx_cnt_q;
    if (tx_flush) begin
      tx_wr_ptr_d = '0;
      tx_rd_ptr_d = '0;
      tx_cnt_d    = '0;
    end else begin
      if (tx_push) tx_wr_ptr_d = tx_wr_ptr_q + PTR_ONE;
      if (tx_pop)  tx_rd_ptr_d = tx_rd_ptr_q + PTR_ONE;
      if (tx_push && !tx_pop)      tx_cnt_d = tx_cnt_q + CNT_ONE;
      else if (!tx_push && tx_pop) tx_cnt_d = tx_cnt_q - CNT_ONE;
    end
  end

  // RX FIFO next state; flush wins over any same-edge push/pop
  always_comb begin
    rx_wr_ptr_d = rx_wr_ptr_q;
    rx_rd_ptr_d = rx_rd_ptr_q;
    rx_cnt_d    = rx_cnt_q;
    if (rx_flush) begin
      rx_wr_ptr_d = '0;
      rx_rd_ptr_d = '0;
      rx_cnt_d    = '0;
    end else begin
      if (rx_push) rx_wr_ptr_d = rx_wr_ptr_q + PTR_ONE;
      if (rx_pop)  rx_rd_ptr_d = rx_rd_ptr_q + PTR_ONE;
      if (rx_push && !rx_pop)      rx_cnt_d = rx_cnt_q + CNT_ONE;
      else if (!rx_push && rx_pop) rx_cnt_d = rx_cnt_q - CNT_ONE;
    end
  end

  // Sticky error flags: a set on the clearing edge takes priority
  always_comb begin
    tx_of_d = (tx_of_q && !rd_s_end) || (wr_d_fire && tx_full);
    rx_uf_d = (rx_uf_q && !rd_s_end) || (rd_d_end && rx_empty);
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      tx_wr_ptr_q <= '0;
      tx_rd_ptr_q <= '0;
      tx_cnt_q    <= '0;
      rx_wr_ptr_q <= '0;
      rx_rd_ptr_q <= '0;
      rx_cnt_q    <= '0;
      tx_of_q     <= 1'b0;
      rx_uf_q     <= 1'b0;
      wr_d_q      <= 1'b0;
      wr_s_q      <= 1'b0;
      rd_d_q      <= 1'b0;
      rd_s_q      <= 1'b0;
    end else begin
      tx_wr_ptr_q <= tx_wr_ptr_d;
      tx_rd_ptr_q <= tx_rd_ptr_d;
      tx_cnt_q    <= tx_cnt_d;
      rx_wr_ptr_q <= rx_wr_ptr_d;
      rx_rd_ptr_q <= rx_rd_ptr_d;
      rx_cnt_q    <= rx_cnt_d;
      tx_of_q     <= tx_of_d;
      rx_uf_q     <= rx_uf_d;
      wr_d_q      <= wr_d;
      wr_s_q      <= wr_s;
      rd_d_q      <= rd_d;
      rd_s_q      <= rd_s;
    end
  end

  // FIFO storage writes; contents are don't-care while counts say empty
  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wr_ptr_q] <= bus;
    if (rx_push) rx_mem[rx_wr_ptr_q] <= rx_data;
  end

endmodule

// File: tb/tb_io_port_responder.sv
// Directed bench for io_port_responder: a vector table for the main traffic plus
// hand-written sequences for same-edge push/pop, flushes and reset mid-access.
module tb_io_port_responder;

  localparam logic [7:0] PB = 8'h00;
  localparam logic [7:0] ST = 8'h01;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] addr_bus;
  logic       mem_io, c_ri, c_ro;
  wire  [7:0] bus;
  logic [7:0] tx_data;
  logic       tx_valid, tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid, rx_ready;

  logic       drv_en;
  logic [7:0] drv_val;
  assign bus = drv_en ? drv_val : 8'hzz;

  always #5 clk = ~clk;

  io_port_responder #(.PORT_BASE(PB), .DEPTH_LOG2(2)) dut (
    .clk      (clk),
    .reset    (reset),
    .addr_bus (addr_bus),
    .mem_io   (mem_io),
    .c_ri     (c_ri),
    .c_ro     (c_ro),
    .bus      (bus),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready)
  );

  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %02h expected %02h", name, act, exp);
    end
  endtask

  task automatic cpu_write(input logic [7:0] a, input logic [7:0] d);
    @(negedge clk);
    addr_bus = a; mem_io = 1'b1; drv_val = d; drv_en = 1'b1; c_ri = 1'b1;
    repeat (3) @(negedge clk);
    c_ri = 1'b0; drv_en = 1'b0; mem_io = 1'b0;
  endtask

  // Checks the bus at the start and at the end of the access; returns after the end edge
  task automatic cpu_read(input logic [7:0] a, input int hold, input logic [7:0] exp,
                          input string name);
    @(negedge clk);
    addr_bus = a; mem_io = 1'b1; c_ro = 1'b1;
    #1 check({name, "_first"}, bus, exp);
    repeat (hold) @(negedge clk);
    check({name, "_last"}, bus, exp);
    c_ro = 1'b0; mem_io = 1'b0;
    @(negedge clk);
  endtask

  task automatic src_push(input logic [7:0] d);
    @(negedge clk);
    rx_valid = 1'b1; rx_data = d;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic sink_pop(input logic [7:0] exp, input string name);
    @(negedge clk);
    check({name, "_valid"}, {7'b0, tx_valid}, 8'h01);
    check({name, "_data"}, tx_data, exp);
    tx_ready = 1'b1;
    @(negedge clk);
    tx_ready = 1'b0;
  endtask

  typedef enum logic [1:0] {OpWr, OpRd, OpRx, OpSink} op_e;
  typedef struct {
    op_e        op;
    logic [7:0] addr;
    logic [7:0] data;   // write data, pushed byte, or expected value
    int         hold;
    string      name;
  } vec_t;

  localparam int NV = 19;
  vec_t vecs[NV];

  initial begin
    reset = 1'b0; addr_bus = 8'h00; mem_io = 1'b0; c_ri = 1'b0; c_ro = 1'b0;
    drv_en = 1'b0; drv_val = 8'h00; tx_ready = 1'b0; rx_data = 8'h00; rx_valid = 1'b0;

    vecs[0]  = '{OpRd,   ST, 8'h0A, 2, "st_reset"};
    vecs[1]  = '{OpWr,   PB, 8'h11, 0, "wr11"};
    vecs[2]  = '{OpWr,   PB, 8'h22, 0, "wr22"};
    vecs[3]  = '{OpWr,   PB, 8'h33, 0, "wr33"};
    vecs[4]  = '{OpWr,   PB, 8'h44, 0, "wr44"};
    vecs[5]  = '{OpWr,   PB, 8'h55, 0, "wr55"};
    vecs[6]  = '{OpRd,   ST, 8'h19, 1, "st_full_of"};
    vecs[7]  = '{OpSink, PB, 8'h11, 0, "sink0"};
    vecs[8]  = '{OpSink, PB, 8'h22, 0, "sink1"};
    vecs[9]  = '{OpSink, PB, 8'h33, 0, "sink2"};
    vecs[10] = '{OpSink, PB, 8'h44, 0, "sink3"};
    // Overflow was cleared by the previous status read; RX still empty
    vecs[11] = '{OpRd,   ST, 8'h0A, 1, "st_drained"};
    vecs[12] = '{OpRx,   PB, 8'hA5, 0, "rxA5"};
    vecs[13] = '{OpRx,   PB, 8'h5A, 0, "rx5A"};
    vecs[14] = '{OpRd,   PB, 8'hA5, 4, "rd_long"};
    vecs[15] = '{OpRd,   PB, 8'h5A, 1, "rd_short"};
    vecs[16] = '{OpRd,   PB, 8'h00, 2, "rd_empty"};
    vecs[17] = '{OpRd,   ST, 8'h2A, 1, "st_underflow"};
    vecs[18] = '{OpRd,   ST, 8'h0A, 1, "st_cleared"};

    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;

    // Reset outputs and bus release
    @(negedge clk);
    check("rst_tx_valid", {7'b0, tx_valid}, 8'h00);
    check("rst_rx_ready", {7'b0, rx_ready}, 8'h01);
    addr_bus = ST; mem_io = 1'b0; c_ro = 1'b1; drv_val = 8'hC3; drv_en = 1'b1;
    #1 check("float_memspace", bus, 8'hC3);
    addr_bus = 8'h02; mem_io = 1'b1;
    #1 check("float_otheraddr", bus, 8'hC3);
    @(negedge clk);
    c_ro = 1'b0; mem_io = 1'b0; drv_en = 1'b0;

    for (int i = 0; i < NV; i++) begin
      unique case (vecs[i].op)
        OpWr:   cpu_write(vecs[i].addr, vecs[i].data);
        OpRd:   cpu_read(vecs[i].addr, vecs[i].hold, vecs[i].data, vecs[i].name);
        OpRx:   src_push(vecs[i].data);
        OpSink: sink_pop(vecs[i].data, vecs[i].name);
        default: ;
      endcase
    end
    @(negedge clk);
    check("tx_empty_after_drain", {7'b0, tx_valid}, 8'h00);

    // CPU push on the same edge as a sink pop with one entry queued
    cpu_write(PB, 8'h77);
    @(negedge clk);
    check("pp_head", tx_data, 8'h77);
    addr_bus = PB; mem_io = 1'b1; drv_val = 8'h88; drv_en = 1'b1; c_ri = 1'b1; tx_ready = 1'b1;
    @(negedge clk);
    tx_ready = 1'b0;
    check("pp_valid", {7'b0, tx_valid}, 8'h01);
    check("pp_data", tx_data, 8'h88);
    repeat (2) @(negedge clk);
    c_ri = 1'b0; drv_en = 1'b0; mem_io = 1'b0;
    cpu_read(ST, 1, 8'h08, "pp_status");
    sink_pop(8'h88, "pp_sink");
    @(negedge clk);
    check("pp_tx_empty", {7'b0, tx_valid}, 8'h00);

    // Fill RX then flush it through the control port
    src_push(8'h01); src_push(8'h02); src_push(8'h03); src_push(8'h04);
    check("rx_full_ready", {7'b0, rx_ready}, 8'h00);
    cpu_read(ST, 1, 8'h06, "st_rx_full");
    @(negedge clk);
    addr_bus = ST; mem_io = 1'b1; drv_val = 8'h02; drv_en = 1'b1; c_ri = 1'b1;
    @(negedge clk);
    check("flush_rx_ready", {7'b0, rx_ready}, 8'h01);
    repeat (2) @(negedge clk);
    c_ri = 1'b0; drv_en = 1'b0; mem_io = 1'b0;
    cpu_read(ST, 1, 8'h0A, "st_rx_flushed");

    // TX flush
    cpu_write(PB, 8'h9A);
    cpu_write(PB, 8'h9B);
    check("pre_flush_tx_valid", {7'b0, tx_valid}, 8'h01);
    cpu_write(ST, 8'h01);
    @(negedge clk);
    check("flush_tx_valid", {7'b0, tx_valid}, 8'h00);

    // Reset in the middle of a data read: the end-of-access pop must not fire
    src_push(8'hC1);
    src_push(8'hC2);
    @(negedge clk);
    addr_bus = PB; mem_io = 1'b1; c_ro = 1'b1;
    @(negedge clk);
    check("rst_mid_bus", bus, 8'hC1);
    reset = 1'b0;
    @(negedge clk);
    c_ro = 1'b0; mem_io = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    cpu_read(ST, 1, 8'h0A, "st_after_rst");
    src_push(8'hD7);
    cpu_read(PB, 1, 8'hD7, "rd_after_rst");

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
